tcp_header_parser: RTL



---
 rtl/tcp_header_parser.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/tcp_header_parser.sv
// Byte-stream TCP segment parser: captures pseudo-header and TCP header fields,
// skips options by data offset, flags malformed segments and passes payload through.
module tcp_header_parser #(
  parameter int DATA_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [8*DATA_W-1:0] s_data_i,
  input  logic [DATA_W-1:0]   s_keep_i,
  input  logic                s_valid_i,
  input  logic                s_last_i,
  output logic                s_ready_o,
  output logic [31:0]         src_addr_o,
  output logic [31:0]         dst_addr_o,
  output logic [7:0]          protocol_o,
  output logic [15:0]         tcp_len_o,
  output logic [15:0]         src_port_o,
  output logic [15:0]         dst_port_o,
  output logic [31:0]         seq_num_o,
  output logic [31:0]         ack_num_o,
  output logic [3:0]          data_offset_o,
  output logic [7:0]          flags_o,
  output logic [15:0]         win_size_o,
  output logic [15:0]         chksum_o,
  output logic [15:0]         urg_ptr_o,
  output logic                hdr_valid_o,
  input  logic                hdr_ready_i,
  output logic [8*DATA_W-1:0] m_data_o,
  output logic [DATA_W-1:0]   m_keep_o,
  output logic                m_valid_o,
  output logic                m_last_o,
  input  logic                m_ready_i,
  output logic                err_o
);

  typedef enum logic [2:0] {HDR, OPTS, WAIT_HDR, PAYLOAD, DRAIN} state_t;

  localparam logic [6:0] BEAT_B     = 7'(DATA_W);
  localparam logic [6:0] HDR_LAST_B = 7'(32 - DATA_W);

  state_t     state_q, state_d;
  logic [6:0] b_q, b_d, b_inc;
  logic       nopay_q, nopay_d;
  logic       err_q, err_d;
  logic [7:0] hdr_q [32];
  logic [3:0] off;
  logic [6:0] hdr_end;

  // hdr_end is one past the last TCP header/option byte in segment byte numbering
  assign off     = hdr_q[24][7:4];
  assign hdr_end = 7'd12 + {1'b0, off, 2'b00};
  assign b_inc   = b_q + BEAT_B;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HDR;
      b_q     <= '0;
      nopay_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      nopay_q <= nopay_d;
      err_q   <= err_d;
    end
  end

  // b stays below 32 while in HDR, so every lane of the beat lands inside the header
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) hdr_q[i] <= '0;
    end else if (state_q == HDR && s_valid_i) begin
      for (int k = 0; k < DATA_W; k++)
        hdr_q[b_q[4:0] + 5'(k)] <= s_data_i[8*(DATA_W-1-k) +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    nopay_d = nopay_q;
    err_d   = 1'b0;
    unique case (state_q)
      HDR: begin
        if (s_valid_i) begin
          if (b_q == HDR_LAST_B) begin
            b_d = '0;
            if (hdr_q[9] != 8'd6 || off < 4'd5) begin
              err_d   = 1'b1;
              state_d = s_last_i ? HDR : DRAIN;
            end else if (off > 4'd5 && !s_last_i) begin
              b_d     = b_inc;
              state_d = OPTS;
            end else begin
              nopay_d = s_last_i;
              state_d = WAIT_HDR;
            end
          end else if (s_last_i) begin
            err_d = 1'b1;
            b_d   = '0;
          end else begin
            b_d = b_inc;
          end
        end
      end
      OPTS: begin
        if (s_valid_i) begin
          b_d = b_inc;
          if (b_inc == hdr_end) begin
            b_d     = '0;
            nopay_d = s_last_i;
            state_d = WAIT_HDR;
          end else if (s_last_i) begin
            b_d     = '0;
            err_d   = 1'b1;
            state_d = HDR;
          end
        end
      end
      WAIT_HDR: if (hdr_ready_i) state_d = nopay_q ? HDR : PAYLOAD;
      PAYLOAD:  if (s_valid_i && m_ready_i && s_last_i) state_d = HDR;
      DRAIN:    if (s_valid_i && s_last_i) state_d = HDR;
      default:  state_d = HDR;
    endcase
  end

  always_comb begin
    s_ready_o   = 1'b1;
    hdr_valid_o = 1'b0;
    m_valid_o   = 1'b0;
    m_data_o    = '0;
    m_keep_o    = '0;
    m_last_o    = 1'b0;
    unique case (state_q)
      WAIT_HDR: begin
        s_ready_o   = 1'b0;
        hdr_valid_o = 1'b1;
      end
      PAYLOAD: begin
        s_ready_o = m_ready_i;
        m_valid_o = s_valid_i;
        m_data_o  = s_data_i;
        m_keep_o  = s_keep_i;
        m_last_o  = s_last_i;
      end
      default: ;
    endcase
  end

  assign err_o         = err_q;
  assign src_addr_o    = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3]};
  assign dst_addr_o    = {hdr_q[4], hdr_q[5], hdr_q[6], hdr_q[7]};
  assign protocol_o    = hdr_q[9];
  assign tcp_len_o     = {hdr_q[10], hdr_q[11]};
  assign src_port_o    = {hdr_q[12], hdr_q[13]};
  assign dst_port_o    = {hdr_q[14], hdr_q[15]};
  assign seq_num_o     = {hdr_q[16], hdr_q[17], hdr_q[18], hdr_q[19]};
  assign ack_num_o     = {hdr_q[20], hdr_q[21], hdr_q[22], hdr_q[23]};
  assign data_offset_o = off;
  assign flags_o       = hdr_q[25];
  assign win_size_o    = {hdr_q[26], hdr_q[27]};
  assign chksum_o      = {hdr_q[28], hdr_q[29]};
  assign urg_ptr_o     = {hdr_q[30], hdr_q[31]};

endmodule
